// File: rtl/ibutterfly4_seq.sv
// ibutterfly4_seq: sequential inverse of a two-stage 4-point butterfly.
// It collects y0..y3, undoes the butterfly in two halving stages, and then
// streams x0..x3 out. Odd intermediate sums mean information was lost to the
// halving, and such sums are reported on out_err.
module ibutterfly4_seq #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_err
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    STG1 = 2'd1,
    STG2 = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             err_q, err_d;

  // A single four-entry register file holds y, then p, then x. Each stage
  // overwrites it in place.
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];

  // Halved results and parity bits of the two butterfly stages
  logic [WIDTH-1:0] s1_res [4];
  logic [WIDTH-1:0] s2_res [4];
  logic [3:0]       s1_odd;
  logic [3:0]       s2_odd;

  genvar gi;

  // Stage 1 pairs y0 with y2 and y1 with y3. Sums go to slots 0 and 1 (p0, p1).
  // Differences go to slots 2 and 3 (p2, p3).
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stg1
      logic [WIDTH:0] sum;
      logic [WIDTH:0] dif;
      // Sign-extend to WIDTH+1 bits so the sum and difference are exact.
      // Dropping bit 0 is then an arithmetic shift right by one.
      assign sum = {data_q[gi][WIDTH-1], data_q[gi]} + {data_q[gi+2][WIDTH-1], data_q[gi+2]};
      assign dif = {data_q[gi][WIDTH-1], data_q[gi]} - {data_q[gi+2][WIDTH-1], data_q[gi+2]};
      assign s1_res[gi]   = sum[WIDTH:1];
      assign s1_res[gi+2] = dif[WIDTH:1];
      assign s1_odd[gi]   = sum[0];
      assign s1_odd[gi+2] = dif[0];
    end
  endgenerate

  // Stage 2 pairs p0 with p1 and p2 with p3. The results land in natural order x0..x3.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stg2
      logic [WIDTH:0] sum;
      logic [WIDTH:0] dif;
      assign sum = {data_q[2*gi][WIDTH-1], data_q[2*gi]} + {data_q[2*gi+1][WIDTH-1], data_q[2*gi+1]};
      assign dif = {data_q[2*gi][WIDTH-1], data_q[2*gi]} - {data_q[2*gi+1][WIDTH-1], data_q[2*gi+1]};
      assign s2_res[2*gi]   = sum[WIDTH:1];
      assign s2_res[2*gi+1] = dif[WIDTH:1];
      assign s2_odd[2*gi]   = sum[0];
      assign s2_odd[2*gi+1] = dif[0];
    end
  endgenerate

  // Next-state logic, datapath selection and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_err   = 1'b0;

    case (state_q)
      LOAD: begin
        // Hold in_ready low while reset is asserted. It rises as soon as reset is released.
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          data_d[cnt_q] = in_data;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = STG1;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      STG1: begin
        data_d  = s1_res;
        // Entering a new block: the error flag restarts from stage-1 parity
        err_d   = |s1_odd;
        state_d = STG2;
      end
      STG2: begin
        data_d  = s2_res;
        err_d   = err_q | (|s2_odd);
        state_d = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = data_q[idx_q];
        out_err   = err_q;
        if (out_ready) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign out_idx = idx_q;

  // State and datapath registers. The register file is cleared on reset so
  // it never presents X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_ibutterfly4_seq.sv
// Testbench for ibutterfly4_seq.
// It applies directed and random blocks and compares against an integer model of the inverse butterfly.
module tb_ibutterfly4_seq;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  int y_blk [4];
  int exp_x [4];
  int exp_err;

  ibutterfly4_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // floor(s/2), written without shifts
  function automatic int half(input int s);
    return (s - (s & 1)) / 2;
  endfunction

  // Reference model: undo the butterfly with plain integer arithmetic
  task automatic set_block(input int a, input int b, input int c, input int d);
    int s [8];
    int p0, p1, p2, p3;
    y_blk[0] = a; y_blk[1] = b; y_blk[2] = c; y_blk[3] = d;
    s[0] = a + c; s[1] = a - c; s[2] = b + d; s[3] = b - d;
    p0 = half(s[0]); p2 = half(s[1]); p1 = half(s[2]); p3 = half(s[3]);
    s[4] = p0 + p1; s[5] = p0 - p1; s[6] = p2 + p3; s[7] = p2 - p3;
    exp_x[0] = half(s[4]); exp_x[1] = half(s[5]);
    exp_x[2] = half(s[6]); exp_x[3] = half(s[7]);
    exp_err = 0;
    for (int i = 0; i < 8; i++) if ((s[i] & 1) != 0) exp_err = 1;
  endtask

  // Offer y_blk[0..n-1], optionally with random bubbles
  task automatic feed(input bit gaps, input int n);
    int k = 0;
    int guard = 0;
    bit acc;
    while (k < n && guard < 200) begin
      @(negedge clk);
      check("in_ready_load", in_ready, 1);
      check("out_valid_load", out_valid, 0);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = W'(y_blk[k]);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) k++;
      guard++;
    end
    if (k < n) check("feed_timeout", k, n);
  endtask

  // Drain four outputs. rmode: 0=always ready, 1=random, 2=pattern 1,0,0,1
  task automatic collect(input int rmode, input bit junk);
    int n = 0;
    int edges = 0;
    int vcyc = 0;
    bit xfer;
    while (n < 4 && edges < 300) begin
      @(negedge clk);
      in_valid = junk;
      in_data  = junk ? W'($urandom) : '0;
      check("in_ready_busy", in_ready, 0);
      check("out_valid_timing", out_valid, (edges >= 2) ? 1 : 0);
      if (out_valid) begin
        check("out_idx", out_idx, n);
        check("out_data", $signed(out_data), exp_x[n]);
        check("out_err", out_err, exp_err);
        case (rmode)
          0: out_ready = 1'b1;
          1: out_ready = 1'($urandom_range(0, 1));
          default: out_ready = (vcyc % 4 == 0 || vcyc % 4 == 3);
        endcase
        vcyc++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      xfer = out_valid && out_ready;
      @(posedge clk);
      if (xfer) n++;
      edges++;
    end
    if (n < 4) check("collect_timeout", n, 4);
    $display("block y=%0d,%0d,%0d,%0d -> x=%0d,%0d,%0d,%0d err=%0d transfers=%0d",
             y_blk[0], y_blk[1], y_blk[2], y_blk[3],
             exp_x[0], exp_x[1], exp_x[2], exp_x[3], exp_err, n);
  endtask

  task automatic reset_checks();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_idx", out_idx, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    #1 check("ready_after_release", in_ready, 1);

    // Basic stream
    set_block(10, -2, -4, 0);
    check("model_basic_x0", exp_x[0], 1);
    feed(1'b0, 4); collect(0, 1'b0);

    // Odd sums everywhere
    set_block(1, 0, 0, 0);
    feed(1'b0, 4); collect(0, 1'b0);

    // Most negative value
    set_block(-16384, -16384, -16384, -16384);
    feed(1'b0, 4); collect(0, 1'b0);

    // Downstream stalls
    set_block(10, -2, -4, 0);
    feed(1'b0, 4); collect(2, 1'b1);

    // Reset mid-block after two accepted samples
    set_block(7, 7, 7, 7);
    feed(1'b0, 2);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1 reset_checks();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_block(10, -2, -4, 0);
    feed(1'b0, 4); collect(0, 1'b0);

    // in_valid held high across two blocks
    set_block(100, -50, 20, 6);
    feed(1'b0, 4); collect(0, 1'b1);
    set_block(-3, 9, 1, -7);
    feed(1'b0, 4); collect(1, 1'b1);

    // Random blocks
    for (int b = 0; b < 25; b++) begin
      set_block(int'($urandom_range(0, 32767)) - 16384, int'($urandom_range(0, 32767)) - 16384,
                int'($urandom_range(0, 32767)) - 16384, int'($urandom_range(0, 32767)) - 16384);
      feed(1'($urandom_range(0, 1)), 4);
      collect(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibutterfly4_seq.md
IBUTTERFLY4_SEQ -- requirements
Module: ibutterfly4_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 15, signed sample width of input and output data.
REQ-002 SHALL have ports, one per line:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  signed forward-butterfly coefficient, order y0,y1,y2,y3.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  signed reconstructed sample, order x0,x1,x2,x3.
- out_idx  output  2  index of the current out_data within the block (0..3).
- out_err  output  1  current block had at least one odd intermediate sum.
REQ-003 SHALL have one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-004 SHALL invert the two-stage 4-point butterfly whose forward form is p0=x0+x1, p1=x0-x1, p2=x2+x3, p3=x2-x3, y0=p0+p2, y2=p0-p2, y1=p1+p3, y3=p1-p3.
REQ-005 SHALL implement a state machine with states LOAD, STG1, STG2, SEND; reset state LOAD.
REQ-006 SHALL, in LOAD: drive in_ready=1; on each in_valid&in_ready, store in_data into slot cnt (0..3) and increment cnt; after slot 3 is stored, go to STG1 and clear cnt.
REQ-007 SHALL, in STG1 (one cycle): compute p0=(y0+y2)>>>1, p2=(y0-y2)>>>1, p1=(y1+y3)>>>1, p3=(y1-y3)>>>1; sums in WIDTH+1 bits, arithmetic shift; result in WIDTH bits; go to STG2.
REQ-008 SHALL, in STG2 (one cycle): compute x0=(p0+p1)>>>1, x1=(p0-p1)>>>1, x2=(p2+p3)>>>1, x3=(p2-p3)>>>1 with the same width rule; go to SEND.
REQ-009 SHALL set an internal error flag when any of the eight WIDTH+1-bit sums/differences in STG1/STG2 has LSB=1; the flag is cleared on entry to STG1.
REQ-010 SHALL, in SEND: drive out_valid=1, out_data=x[out_idx], out_err=error flag; advance out_idx only on out_valid&out_ready; hold out_data/out_idx stable while out_ready=0.
REQ-011 SHALL return to LOAD with out_idx=0 on the cycle after x3 is accepted.
REQ-012 SHALL drive in_ready=0 in STG1, STG2 and SEND; inputs offered there are ignored and not stored.
REQ-013 SHALL drive out_valid=0 outside SEND; out_data and out_err are don't-care when out_valid=0 but SHALL NOT glitch X from the register file.
REQ-014 SHALL have latency: first out_valid two cycles after the clock edge that accepts y3; minimum block period 4+2+4 = 10 cycles.
REQ-015 SHALL handle in_valid gaps in LOAD by holding cnt; partial blocks persist indefinitely.
REQ-016 SHALL need no saturation: all outputs fit in WIDTH bits by construction.

Reset
REQ-017 SHALL, on rst_n=0 at any time including mid-block: state=LOAD, cnt=0, out_idx=0, in_ready=0 while rst_n=0 then 1 from the first cycle after release, out_valid=0, out_err=0, out_data=0, error flag=0; partial data discarded.
REQ-018 SHALL produce no output from a block interrupted by reset.

Verification
REQ-019 Stream 10,-2,-4,0 with out_ready=1 -> out_data 1,2,3,4, out_idx 0..3, out_err=0, first out_valid 2 cycles after y3 accepted.
REQ-020 Stream 1,0,0,0 -> out_data 0,0,0,0, out_err=1 on all four outputs.
REQ-021 Stream -16384,-16384,-16384,-16384 (x=-16384,0,0,0 forward at WIDTH+2 not required; check arithmetic) -> out_data -16384,0,0,0, out_err=0, no wrap.
REQ-022 Valid block with out_ready toggling 1,0,0,1,... -> each x held stable while out_ready=0, exactly four transfers, in_ready=0 until return to LOAD.
REQ-023 Assert rst_n=0 after two inputs accepted, release, stream 10,-2,-4,0 -> output 1,2,3,4 only; no stale samples.
REQ-024 Drive in_valid=1 continuously across two blocks -> in_ready low during STG1/STG2/SEND, second block accepted only from LOAD, both blocks correct.
